// File: rtl/req_encoder.sv
// req_encoder: registered 8-to-3 priority encoder with a valid/ack handshake.
// Requests are captured into sticky pending bits; the lowest-index pending,
// unmasked request is presented as a 3-bit code and held until acknowledged.
module req_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [2:0] code_q;
  logic       valid_q;

  logic [7:0] eligible;
  logic [7:0] clr;
  logic [7:0] nxt;

  // Lowest set index wins; returns 0 when nothing is set (callers gate on != 0).
  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[7 - i]) r = 3'(7 - i);
    end
    return r;
  endfunction

  // Eligibility, the acked bit to clear, and the sticky pending update.
  always_comb begin
    eligible  = pending_q & mask;
    clr       = (valid_q && ack) ? (8'b0000_0001 << code_q) : '0;
    nxt       = eligible & ~clr;
    pending_d = (pending_q & ~clr) | req;
  end

  // Handshake FSM with registered code/valid and the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (eligible != '0) begin
            code_q  <= enc(eligible);
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            if (nxt != '0) begin
              code_q <= enc(nxt);
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule
